// File: rtl/qpsk_bit_combiner_if.sv
// qpsk_bit_combiner_if
//
// Bundles the symbol-input side and the word-output side of the QPSK bit
// combiner into one interface.
//
//   sym_valid   master -> slave  i_bit/q_bit carry a symbol this cycle
//   i_bit       master -> slave  even-stream bit (serial index 0,2,4,...)
//   q_bit       master -> slave  odd-stream bit  (serial index 1,3,5,...)
//   frame_sync  master -> slave  current/next symbol is symbol 0 of a word
//   data_ready  master -> slave  sink accepts data_out
//   data_out    slave -> master  word at the output FIFO head (0 when empty)
//   data_valid  slave -> master  output FIFO is non-empty
//   sym_idx     slave -> master  index of the next expected symbol in the word
//   overflow    slave -> master  sticky: a completed word was dropped
//
// The "slave" modport is the combiner itself; "master" is whatever drives
// the symbols and sinks the words.
interface qpsk_bit_combiner_if #(
    parameter int DATA_W = 8
);
    localparam int IDX_W = $clog2(DATA_W / 2);

    logic              sym_valid;
    logic              i_bit;
    logic              q_bit;
    logic              frame_sync;
    logic              data_ready;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic [IDX_W-1:0]  sym_idx;
    logic              overflow;

    modport master (
        output sym_valid,
        output i_bit,
        output q_bit,
        output frame_sync,
        output data_ready,
        input  data_out,
        input  data_valid,
        input  sym_idx,
        input  overflow
    );

    modport slave (
        input  sym_valid,
        input  i_bit,
        input  q_bit,
        input  frame_sync,
        input  data_ready,
        output data_out,
        output data_valid,
        output sym_idx,
        output overflow
    );
endinterface

// File: rtl/qpsk_bit_combiner.sv
// qpsk_bit_combiner
//
// Receive-side inverse of the QPSK bit splitter. Each accepted symbol
// contributes an (I, Q) bit pair, MSB-first: symbol k carries
// I = word[DATA_W-1-2k] and Q = word[DATA_W-2-2k]. After DATA_W/2 symbols
// the reassembled word is pushed into a small output FIFO that is drained
// with a valid/ready handshake. A word that completes while the FIFO is
// full and not being popped is dropped and sets a sticky overflow flag.
//
// Ports:
//   clk    rising-edge system clock
//   rst_n  synchronous active-low reset
//   bus    qpsk_bit_combiner_if.slave (symbol input, word output, status)
//
// Parameters:
//   DATA_W      output word width, even and >= 4
//   FIFO_DEPTH  output FIFO entries, power of two and >= 2
module qpsk_bit_combiner #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    qpsk_bit_combiner_if.slave    bus
);

    localparam int HALF  = DATA_W / 2;
    localparam int IDX_W = $clog2(HALF);
    localparam int SR_W  = DATA_W - 2;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HALF - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        FIFO_EMPTY   = 2'd0,
        FIFO_PARTIAL = 2'd1,
        FIFO_FULL    = 2'd2
    } fifo_state_e;

    // Only the low DATA_W-2 bits of the shift register are ever needed: the
    // final symbol supplies the last two bits directly on the push edge.
    logic [SR_W-1:0]   sr_q,        sr_d;
    logic [IDX_W-1:0]  sym_idx_q,   sym_idx_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    fifo_state_e       fifo_state_q, fifo_state_d;
    logic              overflow_q,  overflow_d;

    logic [DATA_W-1:0] next_word;
    logic              word_done;
    logic              pop;
    logic              push_ok;

    // Symbol assembly runs independently of the FIFO so a dropped word never
    // disturbs symbol alignment. frame_sync overrides normal shifting: with a
    // valid symbol it restarts the word with that symbol as symbol 0,
    // without one it simply rewinds to symbol 0.
    always_comb begin
        next_word = {sr_q, bus.i_bit, bus.q_bit};
        sr_d      = sr_q;
        sym_idx_d = sym_idx_q;
        word_done = 1'b0;

        if (bus.frame_sync) begin
            if (bus.sym_valid) begin
                sr_d      = SR_W'({bus.i_bit, bus.q_bit});
                sym_idx_d = IDX_W'(1);
            end else begin
                sr_d      = '0;
                sym_idx_d = '0;
            end
        end else if (bus.sym_valid) begin
            sr_d = next_word[SR_W-1:0];
            if (sym_idx_q == LAST_IDX) begin
                sym_idx_d = '0;
                word_done = 1'b1;
            end else begin
                sym_idx_d = sym_idx_q + IDX_W'(1);
            end
        end
    end

    // FIFO bookkeeping. A pop frees the head slot on the same edge, so a
    // completed word is still accepted when the FIFO is full but draining.
    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        fifo_state_d = fifo_state_q;

        pop     = (fifo_state_q != FIFO_EMPTY) && bus.data_ready;
        push_ok = word_done && ((fifo_state_q != FIFO_FULL) || pop);

        if (push_ok) begin
            mem_d[wr_ptr_q] = next_word;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (word_done && !push_ok) begin
            overflow_d = 1'b1;
        end

        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end

        if (count_d == '0) begin
            fifo_state_d = FIFO_EMPTY;
        end else if (count_d == FULL_CNT) begin
            fifo_state_d = FIFO_FULL;
        end else begin
            fifo_state_d = FIFO_PARTIAL;
        end
    end

    // All state is registered here; reset also clears the storage so that
    // nothing stale is ever observable after a reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q         <= '0;
            sym_idx_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            fifo_state_q <= FIFO_EMPTY;
            overflow_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sr_q         <= sr_d;
            sym_idx_q    <= sym_idx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fifo_state_q <= fifo_state_d;
            overflow_q   <= overflow_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // data_out is forced to zero while empty so the sink never sees a stale
    // word from a slot that has already been popped.
    assign bus.data_valid = (fifo_state_q != FIFO_EMPTY);
    assign bus.data_out   = (fifo_state_q != FIFO_EMPTY) ? mem_q[rd_ptr_q] : '0;
    assign bus.sym_idx    = sym_idx_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_qpsk_bit_combiner.sv
// tb_qpsk_bit_combiner
//
// Directed and randomized stimulus for qpsk_bit_combiner (DATA_W=8,
// FIFO_DEPTH=2). A reference model holds the partially received bit stream
// as a plain list of bits and the output FIFO as a queue of words; every
// cycle the DUT outputs are compared against it.
module tb_qpsk_bit_combiner;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 2;

    logic clk;
    logic rst_n;

    qpsk_bit_combiner_if #(.DATA_W(DATA_W)) bus ();

    qpsk_bit_combiner #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          partial[$];
    logic [7:0]  exp_q[$];
    bit          exp_ovf;
    bit          rand_rdy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs (caller is at a negedge), update the
    // model at the rising edge, then compare everything at the next negedge.
    task automatic cycle(input bit sv, input bit i, input bit q, input bit fs, input bit rdy);
        bit         eff_rdy;
        bit         pop;
        bit         done;
        logic [7:0] word;
        eff_rdy        = rand_rdy ? bit'($urandom_range(0, 1)) : rdy;
        bus.sym_valid  = sv;
        bus.i_bit      = i;
        bus.q_bit      = q;
        bus.frame_sync = fs;
        bus.data_ready = eff_rdy;
        @(posedge clk);
        if (!rst_n) begin
            partial.delete();
            exp_q.delete();
            exp_ovf = 1'b0;
        end else begin
            done = 1'b0;
            word = 8'h00;
            if (fs) begin
                partial.delete();
                if (sv) begin
                    partial.push_back(i);
                    partial.push_back(q);
                end
            end else if (sv) begin
                partial.push_back(i);
                partial.push_back(q);
                if (partial.size() == DATA_W) begin
                    for (int j = 0; j < DATA_W; j++) begin
                        word = (word << 1) | 8'(partial[j]);
                    end
                    partial.delete();
                    done = 1'b1;
                end
            end
            pop = (exp_q.size() != 0) && eff_rdy;
            if (pop) begin
                void'(exp_q.pop_front());
            end
            if (done) begin
                if (exp_q.size() < FIFO_DEPTH) begin
                    exp_q.push_back(word);
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
        @(negedge clk);
        check("data_valid", 32'(bus.data_valid), 32'(exp_q.size() != 0));
        check("data_out",   32'(bus.data_out),   (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
        check("sym_idx",    32'(bus.sym_idx),    32'(partial.size() / 2));
        check("overflow",   32'(bus.overflow),   32'(exp_ovf));
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) begin
            cycle(1'b0, 1'($urandom), 1'($urandom), 1'b0, rdy);
        end
    endtask

    // Splits a word into symbols MSB-first using plain shifts, with an
    // optional random gap before each symbol after the first.
    task automatic send_word(input logic [7:0] w, input int max_gap, input bit rdy,
                             input bit last_rdy, input bit fs_first);
        bit ib;
        bit qb;
        for (int k = 0; k < DATA_W / 2; k++) begin
            if (k > 0 && max_gap > 0) begin
                idle($urandom_range(0, max_gap), rdy);
            end
            ib = bit'((w >> (DATA_W - 1 - 2 * k)) & 8'h01);
            qb = bit'((w >> (DATA_W - 2 - 2 * k)) & 8'h01);
            cycle(1'b1, ib, qb, fs_first && (k == 0), (k == DATA_W / 2 - 1) ? last_rdy : rdy);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        rst_n = 1'b1;
    endtask

    initial begin
        rand_rdy       = 1'b0;
        exp_ovf        = 1'b0;
        rst_n          = 1'b0;
        bus.sym_valid  = 1'b0;
        bus.i_bit      = 1'b0;
        bus.q_bit      = 1'b0;
        bus.frame_sync = 1'b0;
        bus.data_ready = 1'b0;
        @(negedge clk);

        // Reset state
        do_reset();
        check("reset_valid", 32'(bus.data_valid), 32'h0);
        check("reset_out",   32'(bus.data_out),   32'h0);

        // Basic word 0xB4, visible one cycle after the last symbol
        send_word(8'hB4, 0, 1'b1, 1'b1, 1'b0);
        check("basic_out", 32'(bus.data_out), 32'hB4);
        check("basic_idx", 32'(bus.sym_idx),  32'h0);
        idle(1, 1'b1);
        check("basic_drained", 32'(bus.data_valid), 32'h0);

        // Gapped input
        for (int r = 0; r < 3; r++) begin
            send_word(8'hB4, 3, 1'b1, 1'b1, 1'b0);
            check("gap_out", 32'(bus.data_out), 32'hB4);
            idle(2, 1'b1);
        end

        // Backpressure and overflow
        do_reset();
        send_word(8'h5A, 0, 1'b0, 1'b0, 1'b0);
        send_word(8'hC3, 0, 1'b0, 1'b0, 1'b0);
        send_word(8'h0F, 0, 1'b0, 1'b0, 1'b0);
        check("bp_head",     32'(bus.data_out), 32'h5A);
        check("bp_overflow", 32'(bus.overflow), 32'h1);
        idle(1, 1'b1);
        check("bp_second",   32'(bus.data_out), 32'hC3);
        idle(1, 1'b1);
        check("bp_empty",    32'(bus.data_valid), 32'h0);
        check("bp_sticky",   32'(bus.overflow),   32'h1);

        // Push and pop on the same edge while full
        do_reset();
        send_word(8'h11, 0, 1'b0, 1'b0, 1'b0);
        send_word(8'h22, 0, 1'b0, 1'b0, 1'b0);
        send_word(8'h33, 0, 1'b0, 1'b1, 1'b0);
        check("pp_head",     32'(bus.data_out), 32'h22);
        check("pp_overflow", 32'(bus.overflow), 32'h0);
        idle(1, 1'b1);
        check("pp_next",     32'(bus.data_out), 32'h33);
        idle(1, 1'b1);

        // frame_sync realignment after garbage
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        send_word(8'hE7, 0, 1'b1, 1'b1, 1'b1);
        check("fs_out", 32'(bus.data_out), 32'hE7);
        idle(1, 1'b1);
        // frame_sync without a symbol rewinds mid-word
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("fs_rewind_idx", 32'(bus.sym_idx), 32'h0);
        send_word(8'h3C, 1, 1'b1, 1'b1, 1'b0);
        check("fs_rewind_out", 32'(bus.data_out), 32'h3C);
        idle(1, 1'b1);

        // Reset mid-operation
        send_word(8'h5A, 0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        check("rst_valid", 32'(bus.data_valid), 32'h0);
        check("rst_out",   32'(bus.data_out),   32'h0);
        check("rst_idx",   32'(bus.sym_idx),    32'h0);
        check("rst_ovf",   32'(bus.overflow),   32'h0);
        send_word(8'h96, 0, 1'b1, 1'b1, 1'b0);
        check("rst_clean", 32'(bus.data_out), 32'h96);
        idle(1, 1'b1);

        // Randomized traffic with random gaps, ready and realignment
        rand_rdy = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if (n % 7 == 3) begin
                cycle(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b1);
                send_word(8'($urandom), 3, 1'b1, 1'b1, 1'b1);
            end else begin
                send_word(8'($urandom), $urandom_range(0, 3), 1'b1, 1'b1, 1'b0);
            end
        end
        rand_rdy = 1'b0;
        idle(4, 1'b1);
        check("final_empty", 32'(bus.data_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qpsk_bit_combiner.md
Name: qpsk_bit_combiner

Overview:
- Receive-side inverse of the modulator's bit splitter: takes demodulated I (even) and Q (odd) bit pairs, one pair per QPSK symbol, and reassembles the original DATA_W-bit words.
- Sits between the QPSK symbol detector and the byte sink.
- Includes symbol-phase alignment, a small output FIFO with valid/ready handshake, and sticky overflow reporting.

Parameters:
- DATA_W, 8, output word width; must be even and ≥4. One word = DATA_W/2 symbols.
- FIFO_DEPTH, 2, output FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- sym_valid  input  1  i_bit/q_bit carry a valid symbol this cycle. No backpressure on this side.
- i_bit  input  1  even-stream bit (serial index 0,2,4,…).
- q_bit  input  1  odd-stream bit (serial index 1,3,5,…).
- frame_sync  input  1  marks the current/next symbol as symbol 0 of a word.
- data_out  output  DATA_W  reassembled word at the FIFO head.
- data_valid  output  1  FIFO non-empty.
- data_ready  input  1  sink accepts data_out.
- sym_idx  output  clog2(DATA_W/2)  index of the next symbol expected within the word.
- overflow  output  1  sticky: a completed word was dropped.

Behaviour:
- Bit order is MSB-first. Symbol k (k = 0..DATA_W/2-1) carries I = word[DATA_W-1-2k] and Q = word[DATA_W-2-2k].
- Symbol accept: on sym_valid=1, sr <= {sr[DATA_W-3:0], i_bit, q_bit} and sym_idx increments.
- sym_idx wraps to 0 after DATA_W/2-1.
- Word completion: accepting symbol index DATA_W/2-1 forms {sr[DATA_W-3:0], i_bit, q_bit} and pushes it into the FIFO on that same edge.
  - data_valid is high in the next cycle (latency 1 clk from the last symbol).
- Gaps: sym_valid=0 holds sr and sym_idx unchanged. Any gap length is allowed.
- frame_sync with sym_valid=1: partial word discarded; this symbol is loaded as symbol 0 (sym_idx -> 1); no push occurs.
- frame_sync with sym_valid=0: partial word discarded; sym_idx -> 0.
- frame_sync never affects FIFO contents.
- Output handshake:
  - Pop when data_valid & data_ready.
  - data_out always shows the head entry and is stable while data_valid & !data_ready.
  - data_out = 0 when the FIFO is empty.
- Simultaneous push and pop:
  - Allowed at any occupancy, including full. Count is unchanged; the pushed word is not dropped.
  - Push into an empty FIFO is not visible until the next cycle (no combinational bypass).
- Full without pop: a completed word is discarded and overflow <= 1. overflow is cleared only by reset.
- Symbol assembly is independent of FIFO state. A drop never stalls or desynchronises sym_idx.
- Reset (rst_n=0 at a clock edge), including mid-word or mid-handshake:
  - sr=0, sym_idx=0, FIFO empty, data_valid=0, data_out=0, overflow=0.
  - Inputs are ignored during reset.
- State summary:
  - sym_idx acts as a DATA_W/2-state counter (IDLE ≡ idx 0).
  - FIFO states are EMPTY, PARTIAL and FULL, driven by the count register (0..FIFO_DEPTH).

Test Plan:
- Basic word: DATA_W=8, data_ready=1, symbols (I,Q) = (1,0),(1,1),(0,1),(0,0) on consecutive cycles -> data_out=0xB4 with data_valid high for exactly 1 cycle, starting 1 clk after the 4th symbol; sym_idx back to 0.
- Gapped input: same 0xB4 symbols with 0–3 idle cycles inserted randomly between symbols -> identical 0xB4 output; sym_idx holds during gaps.
- Backpressure/overflow: data_ready=0, send words 0x5A, 0xC3, 0x0F back-to-back ->
  - data_valid stays high with data_out=0x5A stable.
  - 0x0F is dropped and overflow=1.
  - Then with data_ready=1 -> 0x5A then 0xC3 pop; overflow remains 1.
- Push/pop when full: FIFO holds 0x11, 0x22; complete 0x33 in the same cycle data_ready=1 -> no overflow; outputs 0x22 then 0x33.
- frame_sync realignment: send 2 symbols of garbage, then frame_sync with the first symbol of 0xE7 plus its 3 remaining symbols -> only 0xE7 emitted.
- Reset mid-operation: FIFO holding 1 word with 2 symbols partially assembled, assert rst_n=0 for 1 cycle ->
  - data_valid=0, data_out=0, sym_idx=0, overflow=0.
  - The next 4 symbols form a clean word.
